// File: rtl/spi_slave_frame_pkg.sv
// spi_slave_pkg: frame states, command codes and counter-width helper shared by spi_slave_frame
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT,
        DONE
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    function automatic int spi_width_f(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/spi_slave_frame_if.sv
// spi_slave_frame_if: SPI pins plus command-word and read-data handshake to the memory controller
interface spi_slave_frame_if #(
    parameter int DATA_W = 8
);
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ack;
    logic              busy;
    logic              rx_err;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid, tx_ack, busy, rx_err
    );

    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid, tx_ack, busy, rx_err
    );
endinterface

// File: rtl/spi_slave_frame_shreg.sv
// spi_shreg: bidirectional shift register with parallel load, used for both RX and TX paths
module spi_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             msb_first_i,
    input  logic             ser_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;

    assign q_o = q_q;

    // load wins over shift; shifting moves toward the MSB when msb_first_i, else toward the LSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else if (load_i) q_q <= din_i;
        else if (shift_i) q_q <= msb_first_i ? {q_q[WIDTH-2:0], ser_i} : {ser_i, q_q[WIDTH-1:1]};
    end
endmodule

// File: rtl/spi_slave_frame.sv
// spi_slave_frame: SPI slave frame decoder with read-data return; SPI_SLAVE_PARITY_EN adds odd parity per word
module spi_slave_frame
    import spi_slave_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    spi_slave_frame_if.slave bus
);
    localparam int W  = DATA_W + 2;
    localparam int CW = spi_width_f(W);
    localparam logic [CW-1:0] LAST_TX = CW'(DATA_W - 1);
`ifdef SPI_SLAVE_PARITY_EN
    localparam logic [CW-1:0] LAST_RX = CW'(W);
`else
    localparam logic [CW-1:0] LAST_RX = CW'(W - 1);
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rd_pending_q, rd_pending_d;
    logic [W-1:0]      rx_data_q, rx_data_d;
    logic [W-1:0]      rx_q, word;
    logic [DATA_W-1:0] tx_q;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_err_q, rx_err_d;
    logic              tx_ack_q, tx_ack_d;
    logic              busy_q;
    logic              abort, rx_shift, tx_load, tx_shift, word_ok;
    logic              unused_bits;

`ifdef SPI_SLAVE_PARITY_EN
    // the word is already complete when the parity bit arrives; odd parity over word plus parity bit
    assign word    = rx_q;
    assign word_ok = ^{rx_q, bus.mosi};
`else
    // the last word bit arrives on the completing edge, so splice it in ahead of the shift register
    assign word    = MSB_FIRST ? {rx_q[W-2:0], bus.mosi} : {bus.mosi, rx_q[W-1:1]};
    assign word_ok = 1'b1;
`endif

    assign abort        = (state_q != IDLE) && bus.ss_n;
    assign bus.miso     = MSB_FIRST ? tx_q[DATA_W-1] : tx_q[0];
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_err   = rx_err_q;
    assign bus.tx_ack   = tx_ack_q;
    assign bus.busy     = busy_q;
    assign unused_bits  = ^{tx_q, rx_q};

    spi_shreg #(.WIDTH(W)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b0),
        .shift_i     (rx_shift),
        .msb_first_i (MSB_FIRST),
        .ser_i       (bus.mosi),
        .din_i       ('0),
        .q_o         (rx_q)
    );

    // TX shifts in zeros, so miso falls to 0 by itself once the last bit has gone; abort clears it at once
    spi_shreg #(.WIDTH(DATA_W)) u_tx (
        .clk         (clk),
        .rst         (rst),
        .load_i      (tx_load | abort),
        .shift_i     (tx_shift),
        .msb_first_i (MSB_FIRST),
        .ser_i       (1'b0),
        .din_i       (tx_load ? bus.tx_data : '0),
        .q_o         (tx_q)
    );

    // frame decode: next state, bit counter, pending-read flag and one-cycle strobes
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        rd_pending_d = rd_pending_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_err_d     = 1'b0;
        tx_ack_d     = 1'b0;
        rx_shift     = 1'b0;
        tx_load      = 1'b0;
        tx_shift     = 1'b0;
        if (abort) begin
            state_d = IDLE;
            if (state_q == TX_WAIT || state_q == TX_SHIFT) rd_pending_d = 1'b0;
        end else begin
            case (state_q)
                IDLE:    state_d = bus.ss_n ? IDLE : CHK_CMD;
                CHK_CMD: state_d = !bus.mosi ? WRITE : rd_pending_q ? READ_DATA : READ_ADD;
                WRITE, READ_ADD, READ_DATA: begin
                    rx_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_RX) begin
                        cnt_d      = '0;
                        rx_valid_d = word_ok;
                        rx_err_d   = !word_ok;
                        if (word_ok) rx_data_d = word;
                        if (word_ok && state_q == READ_ADD) rd_pending_d = 1'b1;
                        state_d = (word_ok && state_q == READ_DATA) ? TX_WAIT : DONE;
                    end
                end
                TX_WAIT: begin
                    if (bus.tx_valid) begin
                        tx_load  = 1'b1;
                        tx_ack_d = 1'b1;
                        state_d  = TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    tx_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_TX) begin
                        cnt_d        = '0;
                        rd_pending_d = 1'b0;
                        state_d      = DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // state and registered outputs; busy tracks the state being entered so it has no extra lag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_pending_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_err_q     <= 1'b0;
            tx_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_pending_q <= rd_pending_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_err_q     <= rx_err_d;
            tx_ack_q     <= tx_ack_d;
            busy_q       <= state_d != IDLE;
        end
    end
endmodule

// File: doc/spi_slave_frame.md
# spi_slave_frame

Parametrised SPI slave front-end for the register/RAM path: receives command frames on a single-wire MOSI stream clocked by the system clock, presents `DATA_W+2`-bit command words to the memory controller, and returns read data on MISO. It supersedes the fixed 8-bit slave. It adds a configurable data width, selectable bit order, and a `tx_valid`/`tx_ack` read handshake. Frames aborted by `ss_n` are discarded cleanly, and parity checking is optional.

## Interface
- `DATA_W`, 8, payload width; command word width is `W = DATA_W+2`.
- `MSB_FIRST`, 1, 1 = shift MSB first on both MOSI and MISO; 0 = LSB first.

Ports:
- `clk`  in  1  system clock; all sampling on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `ss_n`  in  1  slave select, active-low.
- `mosi`  in  1  serial input.
- `miso`  out  1  serial output; reset 0.
- `rx_data`  out  W  received command word: `[W-1:W-2]` is the command, `[DATA_W-1:0]` is the payload; reset 0.
- `rx_valid`  out  1  one-cycle strobe, `rx_data` complete; reset 0.
- `tx_data`  in  DATA_W  read data from the memory controller.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ack`  out  1  one-cycle strobe, `tx_data` latched; reset 0.
- `busy`  out  1  high in any state other than IDLE; reset 0.
- `rx_err`  out  1  one-cycle parity-error strobe; reset 0; tied to 0 when parity is compiled out.

## Operation
- States:
  - IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA: frame decode and receive states.
  - TX_WAIT, TX_SHIFT: read-data return states.
  - DONE: end-of-frame hold.
- IDLE → CHK_CMD on the first edge with `ss_n`=0; that edge's MOSI bit is ignored (start cycle).
- CHK_CMD samples the RW bit:
  - RW 0 → WRITE.
  - RW 1 with `rd_pending`=0 → READ_ADD.
  - RW 1 with `rd_pending`=1 → READ_DATA.
- WRITE, READ_ADD, READ_DATA shift W bits into `rx_data`, in the order given by `MSB_FIRST`.
  - The edge sampling bit W loads the final `rx_data` and sets `rx_valid` for exactly one cycle.
  - WRITE goes to DONE after bit W.
  - READ_ADD sets `rd_pending` and goes to DONE.
  - READ_DATA goes to TX_WAIT.
- TX_WAIT holds until `tx_valid`=1. On that edge it latches `tx_data`, pulses `tx_ack`, drives the first bit on `miso`, and goes to TX_SHIFT.
- TX_SHIFT drives the remaining `DATA_W-1` bits, one per cycle. After the last bit, `miso` returns to 0, `rd_pending` clears, and the state goes to DONE.
- DONE holds until `ss_n`=1, then goes to IDLE. No further bits are sampled in DONE.
- Bit counter width is `$clog2(W+2)`. It clears on every state entry and never wraps within a frame.
- Abort: `ss_n`=1 in any non-IDLE state forces IDLE on the next edge.
  - Counter clears and `miso` goes to 0.
  - No `rx_valid` or `tx_ack` is issued.
  - `rx_data` keeps its last completed value.
  - `rd_pending` is kept, except that an abort in TX_WAIT or TX_SHIFT clears it.
- Asynchronous `rst` in any state: all outputs return to reset values immediately, state goes to IDLE, and `rd_pending` clears.
- If `tx_valid` is already high on entry to TX_WAIT, it is accepted on the first TX_WAIT edge.

## Timing
- `rx_valid` rises on the edge that samples the last payload bit, i.e. edge `2+W` after the first `ss_n`-low edge (edge `3+W` with parity).
- MISO latency: first data bit on the edge `tx_valid` is seen in TX_WAIT; last bit `DATA_W-1` cycles later.
- Minimum read-data frame: `2+W+1+DATA_W` cycles with `tx_valid` held high.
- `busy` is registered and follows the state with no extra lag.

## Configuration
- `SPI_SLAVE_PARITY_EN` defined:
  - One odd-parity bit (covering the W word bits) follows the word in WRITE, READ_ADD and READ_DATA.
  - On a match, `rx_valid` rises on the parity edge.
  - On a mismatch, `rx_err` pulses instead, `rx_valid` stays 0, `rd_pending` is unchanged, and the state goes to DONE.
- `SPI_SLAVE_PARITY_EN` undefined: there is no parity bit and `rx_err` is constant 0.

## Structure
- Package `spi_slave_pkg` holds:
  - the state enum;
  - command codes: `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11;
  - a `spi_width_f` helper for counter width.
- One sub-module, `spi_shreg`: a parametrised bidirectional shift register with load, shift and direction controls. It is instantiated once for RX and once for TX.

## Test plan
- Write: `DATA_W`=8; start cycle, RW=0, bits `0010100101` → `rx_data`=10'h0A5, `rx_valid` high for 1 cycle on edge 12, then DONE until `ss_n` rises.
- Read pair:
  - Frame RW=1 `1000000011` → `rx_data`=10'h203 and `rd_pending`=1.
  - Next frame RW=1 `1100000000` → `rx_valid`; `tx_valid`=1 with `tx_data`=8'hC3 → `tx_ack` 1 cycle, `miso` = 1,1,0,0,0,0,1,1, then `rd_pending`=0.
- Abort: `ss_n` rises after 5 WRITE bits → no `rx_valid`, IDLE next edge; the following clean write frame with payload 8'h3C decodes `rx_data`=10'h03C correctly.
- Reset mid-TX_SHIFT after 3 bits: assert `rst` between edges → `miso`=0, `busy`=0 and `rd_pending`=0 immediately.
- `MSB_FIRST`=0, `DATA_W`=16: bits `a[0]`…`a[17]` of word 18'h2ABCD → `rx_data`=18'h2ABCD; read of 16'h8001 drives LSB first: 1, then 0 ×14, then 1.
- With `SPI_SLAVE_PARITY_EN`: write of 10'h0A5 (weight 4) with parity bit 0 → `rx_err` pulse and no `rx_valid`; with parity bit 1 → `rx_valid`.
